generador_onda_cuadrada: RTL and testbench

//  Programmable square-wave generator: the stimulus side of the period-meter chain.

---
 rtl/generador_onda_cuadrada_pkg.sv | 15 +
 rtl/generador_onda_cuadrada_divisor.sv | 40 ++++
 rtl/generador_onda_cuadrada.sv | 201 ++++++++++++++++++++
 tb/tb_generador_onda_cuadrada.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/generador_onda_cuadrada_pkg.sv
// Shared definitions for the programmable square-wave generator.
// Holds the default widths/rates and the FSM state encodings used by
// generador_onda_cuadrada; imported with generador_onda_cuadrada_pkg::*.
package generador_onda_cuadrada_pkg;

    // Default period width (microseconds) and board clock cycles per 1 us.
    localparam int unsigned CANT_BITS_DEF     = 12;
    localparam int unsigned CICLOS_POR_US_DEF = 50;

    // FSM state encodings.
    localparam logic [1:0] PARADO = 2'd0;
    localparam logic [1:0] ALTO   = 2'd1;
    localparam logic [1:0] BAJO   = 2'd2;

endpackage

// File: rtl/generador_onda_cuadrada_divisor.sv
// divisor_tick_us: microsecond prescaler.
// Counts 0..CICLOS_POR_US-1 and asserts tick in the last count, then wraps.
// Ports:
//   reloj_FPGA  in   clock, rising edge
//   reset       in   asynchronous, active-high
//   limpiar     in   synchronous clear (restarts the microsecond)
//   tick        out  high in the last cycle of each microsecond
module divisor_tick_us #(
    parameter int unsigned CICLOS_POR_US = 50
) (
    input  logic reloj_FPGA,
    input  logic reset,
    input  logic limpiar,
    output logic tick
);

    localparam int unsigned W = (CICLOS_POR_US > 1) ? $clog2(CICLOS_POR_US) : 1;
    localparam logic [W-1:0] ULTIMO = W'(CICLOS_POR_US - 1);

    logic [W-1:0] presc_q;
    logic [W-1:0] presc_d;

    always_comb begin
        tick = (presc_q == ULTIMO);
        if (limpiar || tick) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + 1'b1;
        end
    end

    always_ff @(posedge reloj_FPGA or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

endmodule

// File: rtl/generador_onda_cuadrada.sv
// generador_onda_cuadrada: programmable square-wave generator.
// Generates onda_cuadrada with a period of periodo_nuevo microseconds. New
// periods are staged in a pending slot and only applied at a period boundary,
// so the output never glitches. A requested period of 0 or 1 stops the wave.
// Optional macro GEN_CICLO_TRABAJO_EN adds alto_nuevo (high time in us);
// without it the split is high = P - (P>>1), low = P>>1.
// Ports:
//   reloj_FPGA        in   clock, rising edge
//   reset             in   asynchronous, active-high
//   periodo_nuevo     in   requested period in us (0/1 = stop)
//   cargar            in   1-cycle strobe, writes the pending slot
//   alto_nuevo        in   requested high time (GEN_CICLO_TRABAJO_EN only)
//   onda_cuadrada     out  generated wave
//   flanco_pos        out  1-cycle pulse on each 0->1 of the wave
//   activo            out  generator running
//   cambio_pendiente  out  pending slot not yet applied
//   periodo_actual    out  period being generated (0 when stopped)
module generador_onda_cuadrada
    import generador_onda_cuadrada_pkg::*;
#(
    parameter int unsigned CANT_BITS     = CANT_BITS_DEF,
    parameter int unsigned CICLOS_POR_US = CICLOS_POR_US_DEF
) (
    input  logic                 reloj_FPGA,
    input  logic                 reset,
    input  logic [CANT_BITS-1:0] periodo_nuevo,
    input  logic                 cargar,
`ifdef GEN_CICLO_TRABAJO_EN
    input  logic [CANT_BITS-1:0] alto_nuevo,
`endif
    output logic                 onda_cuadrada,
    output logic                 flanco_pos,
    output logic                 activo,
    output logic                 cambio_pendiente,
    output logic [CANT_BITS-1:0] periodo_actual
);

    logic [1:0]           estado_q,   estado_d;
    logic                 onda_q,     onda_d;
    logic                 flanco_q,   flanco_d;
    logic [CANT_BITS-1:0] per_q,      per_d;
    logic [CANT_BITS-1:0] alto_q,     alto_d;
    logic [CANT_BITS-1:0] bajo_q,     bajo_d;
    logic [CANT_BITS-1:0] cuenta_q,   cuenta_d;
    logic                 pend_q,     pend_d;
    logic [CANT_BITS-1:0] pend_per_q, pend_per_d;
`ifdef GEN_CICLO_TRABAJO_EN
    logic [CANT_BITS-1:0] pend_alto_q, pend_alto_d;
`endif

    logic                 tick;
    logic                 limpiar;
    logic                 pend_valido;
    logic [CANT_BITS-1:0] h_pend;
    logic [CANT_BITS-1:0] l_pend;

    divisor_tick_us #(
        .CICLOS_POR_US (CICLOS_POR_US)
    ) u_divisor (
        .reloj_FPGA (reloj_FPGA),
        .reset      (reset),
        .limpiar    (limpiar),
        .tick       (tick)
    );

    // High/low split of the pending value, computed once when it is applied.
    always_comb begin
        pend_valido = (pend_per_q >= CANT_BITS'(2));
        h_pend      = pend_per_q - (pend_per_q >> 1);
`ifdef GEN_CICLO_TRABAJO_EN
        // Out-of-range high times fall back to the ceil split.
        if ((pend_alto_q != '0) && (pend_alto_q < pend_per_q)) begin
            h_pend = pend_alto_q;
        end
`endif
        l_pend = pend_per_q - h_pend;
    end

    always_comb begin
        estado_d   = estado_q;
        onda_d     = onda_q;
        flanco_d   = 1'b0;
        per_d      = per_q;
        alto_d     = alto_q;
        bajo_d     = bajo_q;
        cuenta_d   = cuenta_q;
        pend_d     = pend_q;
        pend_per_d = pend_per_q;
`ifdef GEN_CICLO_TRABAJO_EN
        pend_alto_d = pend_alto_q;
`endif
        limpiar    = 1'b0;

        case (estado_q)
            PARADO: begin
                if (pend_q) begin
                    pend_d = 1'b0;
                    if (pend_valido) begin
                        per_d    = pend_per_q;
                        alto_d   = h_pend;
                        bajo_d   = l_pend;
                        cuenta_d = '0;
                        onda_d   = 1'b1;
                        flanco_d = 1'b1;
                        limpiar  = 1'b1;
                        estado_d = ALTO;
                    end
                end
            end
            ALTO: begin
                if (tick) begin
                    if (cuenta_q == alto_q - 1'b1) begin
                        onda_d   = 1'b0;
                        cuenta_d = '0;
                        estado_d = BAJO;
                    end else begin
                        cuenta_d = cuenta_q + 1'b1;
                    end
                end
            end
            BAJO: begin
                if (tick) begin
                    if (cuenta_q == bajo_q - 1'b1) begin
                        // Period boundary: the only point where the slot is consumed.
                        cuenta_d = '0;
                        if (!pend_q || pend_valido) begin
                            if (pend_q) begin
                                per_d  = pend_per_q;
                                alto_d = h_pend;
                                bajo_d = l_pend;
                            end
                            pend_d   = 1'b0;
                            onda_d   = 1'b1;
                            flanco_d = 1'b1;
                            limpiar  = 1'b1;
                            estado_d = ALTO;
                        end else begin
                            pend_d   = 1'b0;
                            per_d    = '0;
                            onda_d   = 1'b0;
                            estado_d = PARADO;
                        end
                    end else begin
                        cuenta_d = cuenta_q + 1'b1;
                    end
                end
            end
            default: begin
                estado_d = PARADO;
                onda_d   = 1'b0;
                per_d    = '0;
            end
        endcase

        // A load in the same cycle as a boundary lands after the old slot was used.
        if (cargar) begin
            pend_d     = 1'b1;
            pend_per_d = periodo_nuevo;
`ifdef GEN_CICLO_TRABAJO_EN
            pend_alto_d = alto_nuevo;
`endif
        end
    end

    always_ff @(posedge reloj_FPGA or posedge reset) begin
        if (reset) begin
            estado_q   <= PARADO;
            onda_q     <= 1'b0;
            flanco_q   <= 1'b0;
            per_q      <= '0;
            alto_q     <= '0;
            bajo_q     <= '0;
            cuenta_q   <= '0;
            pend_q     <= 1'b0;
            pend_per_q <= '0;
`ifdef GEN_CICLO_TRABAJO_EN
            pend_alto_q <= '0;
`endif
        end else begin
            estado_q   <= estado_d;
            onda_q     <= onda_d;
            flanco_q   <= flanco_d;
            per_q      <= per_d;
            alto_q     <= alto_d;
            bajo_q     <= bajo_d;
            cuenta_q   <= cuenta_d;
            pend_q     <= pend_d;
            pend_per_q <= pend_per_d;
`ifdef GEN_CICLO_TRABAJO_EN
            pend_alto_q <= pend_alto_d;
`endif
        end
    end

    assign onda_cuadrada    = onda_q;
    assign flanco_pos       = flanco_q;
    assign activo           = (estado_q != PARADO);
    assign cambio_pendiente = pend_q;
    assign periodo_actual   = per_q;

endmodule

// File: tb/tb_generador_onda_cuadrada.sv
// Self-checking bench for generador_onda_cuadrada with CICLOS_POR_US=4.
// Stimulus pushes the expected wave segments (level, length in clocks,
// period shown after the transition) into a queue; a monitor pops one entry
// at every transition of onda_cuadrada and compares. Length 0 = don't care.
module tb_generador_onda_cuadrada;

    localparam int unsigned CB  = 12;
    localparam int unsigned CPU = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [CB-1:0] periodo_nuevo = '0;
    logic          cargar = 1'b0;
    logic [CB-1:0] alto_v = '0;
    logic          onda_cuadrada;
    logic          flanco_pos;
    logic          activo;
    logic          cambio_pendiente;
    logic [CB-1:0] periodo_actual;

    generador_onda_cuadrada #(
        .CANT_BITS     (CB),
        .CICLOS_POR_US (CPU)
    ) dut (
        .reloj_FPGA       (clk),
        .reset            (reset),
        .periodo_nuevo    (periodo_nuevo),
        .cargar           (cargar),
`ifdef GEN_CICLO_TRABAJO_EN
        .alto_nuevo       (alto_v),
`endif
        .onda_cuadrada    (onda_cuadrada),
        .flanco_pos       (flanco_pos),
        .activo           (activo),
        .cambio_pendiente (cambio_pendiente),
        .periodo_actual   (periodo_actual)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic lvl;
        int   len;
        int   per;
    } ev_t;

    ev_t q[$];
    int  tests = 0;
    int  fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic exp_ev(input logic l, input int len, input int per);
        ev_t e;
        e.lvl = l;
        e.len = len;
        e.per = per;
        q.push_back(e);
    endtask

    task automatic cargar_p(input int p, input int a);
        periodo_nuevo = CB'(p);
        alto_v        = CB'(a);
        cargar        = 1'b1;
        @(posedge clk); #1;
        cargar        = 1'b0;
    endtask

    task automatic ciclos(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    // Waits (bounded) until the monitor has consumed every expected event.
    task automatic drain(input string name, input int budget);
        int n = 0;
        while (q.size() != 0 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        chk({name, "_pendientes"}, q.size(), 0);
        q.delete();
    endtask

    // Monitor: segment scoreboard plus flanco_pos checked against the wave.
    int   cyc = 0;
    int   last_cyc = 0;
    logic onda_prev = 1'b0;

    always @(negedge clk) begin
        ev_t e;
        cyc++;
        if (onda_cuadrada !== onda_prev) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL flanco_inesperado: got level %0d expected no transition (t=%0t)",
                         onda_cuadrada, $time);
            end else begin
                e = q.pop_front();
                chk("nivel_segmento", onda_prev, e.lvl);
                if (e.len != 0) chk("largo_segmento", cyc - last_cyc, e.len);
                chk("periodo_en_flanco", periodo_actual, e.per);
            end
            last_cyc = cyc;
        end
        chk("flanco_pos", flanco_pos, (onda_cuadrada && !onda_prev) ? 1 : 0);
        onda_prev = onda_cuadrada;
    end

    initial begin
        // Reset state
        ciclos(3);
        chk("rst_onda", onda_cuadrada, 0);
        chk("rst_flanco", flanco_pos, 0);
        chk("rst_activo", activo, 0);
        chk("rst_pendiente", cambio_pendiente, 0);
        chk("rst_periodo", periodo_actual, 0);
        reset = 1'b0;
        ciclos(2);

        // P=10: 20 high / 20 low, first rise two cycles after cargar
        exp_ev(1'b0, 0, 10);
        for (int i = 0; i < 3; i++) begin
            exp_ev(1'b1, 20, 10);
            exp_ev(1'b0, 20, 10);
        end
        cargar_p(10, 0);
        chk("lat_pendiente", cambio_pendiente, 1);
        chk("lat_onda_n1", onda_cuadrada, 0);
        ciclos(1);
        chk("lat_onda_n2", onda_cuadrada, 1);
        chk("lat_flanco_n2", flanco_pos, 1);
        chk("lat_activo", activo, 1);
        chk("lat_periodo", periodo_actual, 10);
        chk("lat_pend_limpio", cambio_pendiente, 0);
        drain("p10", 300);

        // P=4 loaded mid-high: current 40-clk period completes, then 16-clk periods
        ciclos(3);
        exp_ev(1'b1, 20, 10);
        exp_ev(1'b0, 20, 4);
        for (int i = 0; i < 2; i++) begin
            exp_ev(1'b1, 8, 4);
            exp_ev(1'b0, 8, 4);
        end
        cargar_p(4, 0);
        chk("p4_pendiente", cambio_pendiente, 1);
        chk("p4_periodo_aun10", periodo_actual, 10);
        drain("p4", 200);
        chk("p4_periodo", periodo_actual, 4);

        // P=7: 16 high / 12 low
        exp_ev(1'b1, 8, 4);
        exp_ev(1'b0, 8, 7);
        for (int i = 0; i < 2; i++) begin
            exp_ev(1'b1, 16, 7);
            exp_ev(1'b0, 12, 7);
        end
        cargar_p(7, 0);
        drain("p7", 200);
        chk("p7_periodo", periodo_actual, 7);
        chk("p7_activo", activo, 1);

        // Two loads before the boundary: only the last (9) is applied
        exp_ev(1'b1, 16, 7);
        exp_ev(1'b0, 12, 9);
        exp_ev(1'b1, 20, 9);
        exp_ev(1'b0, 16, 9);
        cargar_p(5, 0);
        cargar_p(9, 0);
        drain("p5_p9", 200);
        chk("p9_periodo", periodo_actual, 9);

        // P=1 stops the wave at the next boundary (no transition at the stop)
        exp_ev(1'b1, 20, 9);
        cargar_p(1, 0);
        drain("stop", 100);
        ciclos(5);
        chk("stop_activo_antes", activo, 1);
        chk("stop_periodo_antes", periodo_actual, 9);
        ciclos(15);
        chk("stop_activo", activo, 0);
        chk("stop_periodo", periodo_actual, 0);
        chk("stop_onda", onda_cuadrada, 0);
        chk("stop_pendiente", cambio_pendiente, 0);

`ifdef GEN_CICLO_TRABAJO_EN
        // alto=3 -> 12/28; alto=12 (>=P) -> clamped to 20/20
        exp_ev(1'b0, 0, 10);
        exp_ev(1'b1, 12, 10);
        exp_ev(1'b0, 28, 10);
        cargar_p(10, 3);
        drain("alto3", 200);
        exp_ev(1'b1, 12, 10);
        exp_ev(1'b0, 28, 10);
        exp_ev(1'b1, 20, 10);
        exp_ev(1'b0, 20, 10);
        cargar_p(10, 12);
        drain("alto12", 200);
        exp_ev(1'b1, 20, 10);
        cargar_p(0, 0);
        drain("alto_stop", 100);
        ciclos(25);
        chk("alto_stop_activo", activo, 0);
`endif

        // Reset asserted mid-high: output drops immediately, no restart afterwards
        exp_ev(1'b0, 0, 10);
        cargar_p(10, 0);
        drain("p10_b", 50);
        ciclos(2);
        exp_ev(1'b1, 0, 0);
        #1 reset = 1'b1;
        #1;
        chk("rst_async_onda", onda_cuadrada, 0);
        chk("rst_async_activo", activo, 0);
        chk("rst_async_periodo", periodo_actual, 0);
        ciclos(2);
        reset = 1'b0;
        ciclos(30);
        chk("post_rst_onda", onda_cuadrada, 0);
        chk("post_rst_activo", activo, 0);
        chk("post_rst_pendiente", cambio_pendiente, 0);
        drain("rst", 5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
